shift_seq: RTL

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/shift_seq.sv
// Multi-cycle barrel shifter: one power-of-two stage per clock (SLL, SRA, ROR).
// Optional early completion when SHIFT_EARLY_DONE_EN is defined.
module shift_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] shift_in,
    input  logic [3:0]  shift_val,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic [15:0] shift_out,
    output logic        err,
    output logic [1:0]  dbg_state
);

    // Handshake: start is a level sampled on a rising edge only in IDLE; the
    // result is valid when done is high (one cycle) and then holds until the
    // next accepted start. There is no ready/backpressure on the result side.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  k, k_nxt;
    logic [15:0] work, work_nxt;
    logic [3:0]  amt, amt_nxt;
    logic [1:0]  md, md_nxt;
    logic [15:0] out_nxt;
    logic        err_nxt;

    logic [3:0]  step;
    logic [31:0] rot;
    logic [15:0] staged;
    logic [15:0] stage_res;
    logic        last_stage;

    // Stage k shifts by 2^k; rotate takes the low half of the doubled word.
    always_comb begin
        step = 4'd1 << k;
        rot  = {work, work} >> step;
        case (md)
            2'b00:   staged = work << step;
            2'b01:   staged = $unsigned($signed(work) >>> step);
            default: staged = rot[15:0];
        endcase
        stage_res = amt[k] ? staged : work;
`ifdef SHIFT_EARLY_DONE_EN
        last_stage = (k == 2'd3) || ((amt >> ({1'b0, k} + 3'd1)) == 4'd0);
`else
        last_stage = (k == 2'd3);
`endif
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        work_nxt  = work;
        amt_nxt   = amt;
        md_nxt    = md;
        out_nxt   = shift_out;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    work_nxt = shift_in;
                    amt_nxt  = shift_val;
                    md_nxt   = mode;
                    k_nxt    = 2'd0;
                    err_nxt  = 1'b0;
                    if (mode == 2'b11) begin
                        err_nxt   = 1'b1;
                        out_nxt   = shift_in;
                        state_nxt = DONE;
                    end
`ifdef SHIFT_EARLY_DONE_EN
                    else if (shift_val == 4'd0) begin
                        out_nxt   = shift_in;
                        state_nxt = DONE;
                    end
`endif
                    else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_nxt = stage_res;
                k_nxt    = k + 2'd1;
                if (last_stage) begin
                    out_nxt   = stage_res;
                    k_nxt     = 2'd0;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= 2'd0;
            work      <= 16'h0000;
            amt       <= 4'd0;
            md        <= 2'b00;
            shift_out <= 16'h0000;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            work      <= work_nxt;
            amt       <= amt_nxt;
            md        <= md_nxt;
            shift_out <= out_nxt;
            err       <= err_nxt;
        end
    end

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule
